peak_detector: RTL
==================

Name: peak_detector

Overview:
- Sits directly downstream of the trapezoidal shaping filter. Consumes its shaped-output sample stream at one sample per clock.
- Detects pulses by threshold crossing and extracts each pulse's peak amplitude and timestamp.
- Presents each result as one event on a valid/ready output port, for the histogramming/readout stage.
- Flags over-long (piled-up) pulses and counts events dropped through back-pressure.

Parameters:
- SIZE_ADC_DATA, from package_settings; sample width, shared with the filter output.
- TS_WIDTH, 32; timestamp counter width.
- HOLDOFF, 16; dead-time in clocks after each pulse end (>=1).
- MAX_PULSE, 64; maximum samples above threshold before the pulse is declared piled-up (>=2).

Ports:
- clk  in  1  system clock; one filter sample per rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- input_data  in  SIZE_ADC_DATA  shaped filter output, unsigned.
- threshold  in  SIZE_ADC_DATA  trigger level, unsigned.
- peak_valid  out  1  event available.
- peak_ready  in  1  consumer accepts the event.
- peak_amp  out  SIZE_ADC_DATA  maximum sample of the pulse.
- peak_time  out  TS_WIDTH  timestamp of the maximum sample.
- pileup  out  1  event terminated by MAX_PULSE.
- lost_cnt  out  16  saturating count of dropped events.

Behaviour:
- Reset (async, active-low): all outputs are 0, state is IDLE, timestamp counter is 0.
  - Reset mid-pulse or mid-handshake discards everything, with no event emitted.
- Timestamp counter: free-running, wraps modulo 2^TS_WIDTH. The first edge after reset release samples value 0. Sample k is the sample captured at the edge where the counter equals k.
- Comparison: hit = input_data > threshold, strict and unsigned. Threshold is read every cycle; it is not latched.
- IDLE state:
  - On hit: go to RISE; max <= input_data, tmax <= counter, len <= 1.
  - Otherwise stay in IDLE.
- RISE state:
  - On hit, when input_data > max (strict; ties keep the earlier time): max and tmax are updated. len increments.
  - On !hit: finish the event with pileup=0, then go to HOLD.
  - When hit and len == MAX_PULSE: finish the event with pileup=1. The current sample is not included. Then go to HOLD.
- HOLD state: input is ignored for HOLDOFF edges, counting the finishing edge as none. Then go to IDLE. A hit arriving on the first IDLE edge starts a new pulse.
- Finish (the same edge as the transition):
  - If the output slot is free, or is being accepted this cycle (peak_valid && peak_ready): load peak_amp=max, peak_time=tmax, pileup; peak_valid <= 1.
  - Otherwise: the new event is dropped and lost_cnt increments, saturating at 0xFFFF.
- Latency: peak_valid is high in the cycle after the ending edge. Event data appears one clock after the first below-threshold sample.
- Output handshake:
  - peak_valid stays high, and peak_amp/peak_time/pileup stay stable, until an edge with peak_ready=1.
  - peak_valid falls on that edge unless a new event loads on the same edge, in which case it stays high with new data.
  - peak_ready has no effect while peak_valid=0.
- Wrap-around: a pulse spanning a counter wrap reports the raw, wrapped tmax.
- Width rules: no arithmetic on samples, only comparisons. len is a clog2(MAX_PULSE+1)-bit counter. The HOLD counter is clog2(HOLDOFF+1) bits.

Decomposition:
- SIZE_ADC_DATA stays in package_settings.
- New package peak_detector_parameters holds:
  - TS_WIDTH, HOLDOFF, MAX_PULSE;
  - LOST_CNT_WIDTH=16;
  - typedef enum logic[1:0] {IDLE, RISE, HOLD} pd_state_t.
- No sub-module is required. The FSM, timestamp counter and output register live in one always block, with async reset.

Test Plan:
- Basic pulse: threshold=10, samples 0,0,5,20,40,30,8,0 (k=0..7), peak_ready=1 → one event: peak_valid high for exactly one cycle after edge 6, peak_amp=40, peak_time=4, pileup=0.
- Tie: threshold=10, samples 0,50,50,0 → peak_amp=50, peak_time=1.
- Pileup: MAX_PULSE=64, threshold=10, 100 samples of 20 starting at k=3 → event finishes at edge 67 with pileup=1, peak_amp=20, peak_time=3. No second event before HOLDOFF expires; after HOLD a new pulse starts at edge 84 → second event.
- Holdoff: pulse 20,40,0 at k=0..2, then 30 at k=5 (inside HOLDOFF=16) → exactly one event. A 30 at k=19 produces a second event with peak_time=19.
- Back-pressure: peak_ready=0, three separate pulses → the first event is held stable and lost_cnt=2. Then raise peak_ready → valid falls after one edge. Finish and accept on the same edge → peak_valid stays 1 with new data.
- Reset mid-RISE: assert reset during RISE → all outputs 0 immediately (async). After release, the counter restarts at 0 and no event from the aborted pulse is emitted.

Source files
------------

// File: rtl/package_settings.sv
// System-wide settings shared by the shaping filter and its downstream stages.
package package_settings;

  localparam int SIZE_ADC_DATA = 16;

endpackage

// File: rtl/peak_detector_parameters.sv
// Peak detector configuration constants and FSM state encoding.
package peak_detector_parameters;

  localparam int TS_WIDTH       = 32;
  localparam int HOLDOFF        = 16;
  localparam int MAX_PULSE      = 64;
  localparam int LOST_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    HOLD = 2'd2
  } pd_state_t;

endpackage

// File: rtl/peak_detector.sv
// Threshold-triggered peak detector: extracts each pulse's maximum and its timestamp
// and presents it as one event on a valid/ready port, counting events lost to back-pressure.
module peak_detector
  import package_settings::*;
  import peak_detector_parameters::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SIZE_ADC_DATA-1:0]  input_data,
  input  logic [SIZE_ADC_DATA-1:0]  threshold,
  output logic                      peak_valid,
  input  logic                      peak_ready,
  output logic [SIZE_ADC_DATA-1:0]  peak_amp,
  output logic [TS_WIDTH-1:0]       peak_time,
  output logic                      pileup,
  output logic [LOST_CNT_WIDTH-1:0] lost_cnt
);

  localparam int LEN_W  = $clog2(MAX_PULSE + 1);
  localparam int HOLD_W = $clog2(HOLDOFF + 1);

  pd_state_t                 state_q, state_d;
  logic [TS_WIDTH-1:0]       ts_q, ts_d;
  logic [SIZE_ADC_DATA-1:0]  max_q, max_d;
  logic [TS_WIDTH-1:0]       tmax_q, tmax_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [HOLD_W-1:0]         hold_q, hold_d;
  logic                      valid_q, valid_d;
  logic [SIZE_ADC_DATA-1:0]  amp_q, amp_d;
  logic [TS_WIDTH-1:0]       time_q, time_d;
  logic                      pile_q, pile_d;
  logic [LOST_CNT_WIDTH-1:0] lost_q, lost_d;

  logic hit_s;
  logic finish_s;
  logic finish_pile_s;

  assign hit_s = (input_data > threshold);

  // Next-state logic for the pulse FSM, timestamp and output slot.
  always_comb begin
    state_d       = state_q;
    ts_d          = ts_q + TS_WIDTH'(1);
    max_d         = max_q;
    tmax_d        = tmax_q;
    len_d         = len_q;
    hold_d        = hold_q;
    finish_s      = 1'b0;
    finish_pile_s = 1'b0;
    valid_d       = valid_q;
    amp_d         = amp_q;
    time_d        = time_q;
    pile_d        = pile_q;
    lost_d        = lost_q;

    case (state_q)
      IDLE: begin
        if (hit_s) begin
          state_d = RISE;
          max_d   = input_data;
          tmax_d  = ts_q;
          len_d   = LEN_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      RISE: begin
        if (!hit_s) begin
          finish_s = 1'b1;
          state_d  = HOLD;
          hold_d   = HOLD_W'(0);
        end else if (len_q == LEN_W'(MAX_PULSE)) begin
          // Piled-up pulse: the current sample is not part of it.
          finish_s      = 1'b1;
          finish_pile_s = 1'b1;
          state_d       = HOLD;
          hold_d        = HOLD_W'(0);
        end else begin
          len_d = len_q + LEN_W'(1);
          if (input_data > max_q) begin
            max_d  = input_data;
            tmax_d = ts_q;
          end else begin
            max_d  = max_q;
          end
        end
      end
      HOLD: begin
        if (hold_q == HOLD_W'(HOLDOFF - 1)) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A finishing event may reuse the slot on the same edge it is accepted.
    if (finish_s && (!valid_q || peak_ready)) begin
      valid_d = 1'b1;
      amp_d   = max_q;
      time_d  = tmax_q;
      pile_d  = finish_pile_s;
    end else if (finish_s) begin
      if (lost_q != {LOST_CNT_WIDTH{1'b1}}) begin
        lost_d = lost_q + LOST_CNT_WIDTH'(1);
      end else begin
        lost_d = lost_q;
      end
    end else if (valid_q && peak_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // All detector state: FSM, timestamp counter and output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ts_q    <= '0;
      max_q   <= '0;
      tmax_q  <= '0;
      len_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      amp_q   <= '0;
      time_q  <= '0;
      pile_q  <= 1'b0;
      lost_q  <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      max_q   <= max_d;
      tmax_q  <= tmax_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      amp_q   <= amp_d;
      time_q  <= time_d;
      pile_q  <= pile_d;
      lost_q  <= lost_d;
    end
  end

  assign peak_valid = valid_q;
  assign peak_amp   = amp_q;
  assign peak_time  = time_q;
  assign pileup     = pile_q;
  assign lost_cnt   = lost_q;

endmodule
